// File: rtl/pipe_cla_subtractor.sv
// pipe_cla_subtractor: two-stage pipelined WIDTH-bit subtractor, DIFF = A + ~B + 1.
// Stage 1 resolves the lower half over 4-bit carry-lookahead groups (carry-in 1).
// Stage 2 resolves the upper half from the registered carry and produces the flags.
// Valid/ready handshake on both sides sustains one operation per cycle.
// Optional build macro: SUB_SAT_EN selects unsigned saturation. With this option,
// a borrow clamps out_diff to zero, and out_borrow and out_ovf still report the
// unclamped result.
module pipe_cla_subtractor #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_borrow,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int HALF = WIDTH / 2;
  localparam int NGRP = HALF / 4;

  // Lookahead adder over one half.
  // Each 4-bit group computes its bit carries from gc[k] in lookahead form.
  // Group carries ripple as C(k+1) = G | C(k) & P.
  // Returns {carry_out, sum}.
  function automatic logic [HALF:0] cla_half(
    input logic [HALF-1:0] a,
    input logic [HALF-1:0] bn,
    input logic            cin
  );
    logic [HALF-1:0] g;
    logic [HALF-1:0] p;
    logic [HALF-1:0] x;
    logic [HALF-1:0] sum;
    logic [NGRP:0]   gc;
    logic [3:0]      bc;
    logic            grp_g;
    logic            grp_p;
    g     = a & bn;
    p     = a | bn;
    x     = a ^ bn;
    sum   = '0;
    gc    = '0;
    gc[0] = cin;
    for (int k = 0; k < NGRP; k++) begin
      grp_g = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      grp_p = &p[4*k +: 4];
      bc[0] = gc[k];
      bc[1] = g[4*k] | (p[4*k] & gc[k]);
      bc[2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      bc[3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
            | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
      sum[4*k +: 4] = x[4*k +: 4] ^ bc;
      gc[k+1]       = grp_g | (grp_p & gc[k]);
    end
    return {gc[NGRP], sum};
  endfunction

  // Pipeline state
  logic            s1_valid_r;
  logic [HALF-1:0] s1_diff_lo_r;
  logic            s1_carry_r;
  logic [HALF-1:0] s1_a_hi_r;
  logic [HALF-1:0] s1_bn_hi_r;
  logic            s2_valid_r;
  logic [WIDTH-1:0] s2_diff_r;
  logic            s2_borrow_r;
  logic            s2_ovf_r;
  logic            s2_zero_r;

  // Combinational datapath
  logic            adv1_s;
  logic            adv2_s;
  logic [WIDTH-1:0] bn_s;
  logic [HALF:0]   lo_s;
  logic [HALF:0]   hi_s;
  logic [WIDTH-1:0] diff_s;
  logic [WIDTH-1:0] res_s;
  logic            a_msb_s;
  logic            b_msb_s;
  logic            borrow_s;
  logic            ovf_s;
  logic            zero_s;

  assign adv2_s   = !s2_valid_r || out_ready;
  assign adv1_s   = !s1_valid_r || adv2_s;
  assign in_ready = adv1_s;

  // Stage 1 and stage 2 arithmetic: low half from the operands, high half from S1 registers
  always_comb begin
    bn_s     = ~in_b;
    lo_s     = cla_half(in_a[HALF-1:0], bn_s[HALF-1:0], 1'b1);
    hi_s     = cla_half(s1_a_hi_r, s1_bn_hi_r, s1_carry_r);
    diff_s   = {hi_s[HALF-1:0], s1_diff_lo_r};
    a_msb_s  = s1_a_hi_r[HALF-1];
    b_msb_s  = ~s1_bn_hi_r[HALF-1];
    borrow_s = ~hi_s[HALF];
    ovf_s    = (a_msb_s ^ b_msb_s) & (diff_s[WIDTH-1] ^ a_msb_s);
`ifdef SUB_SAT_EN
    if (borrow_s) begin
      res_s = '0;
    end else begin
      res_s = diff_s;
    end
`else
    res_s = diff_s;
`endif
    zero_s = (res_s == '0);
  end

  // Stage 1 register: capture low-half result and upper operands on advance
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r   <= 1'b0;
      s1_diff_lo_r <= '0;
      s1_carry_r   <= 1'b0;
      s1_a_hi_r    <= '0;
      s1_bn_hi_r   <= '0;
    end else if (adv1_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_diff_lo_r <= lo_s[HALF-1:0];
        s1_carry_r   <= lo_s[HALF];
        s1_a_hi_r    <= in_a[WIDTH-1:HALF];
        s1_bn_hi_r   <= bn_s[WIDTH-1:HALF];
      end
    end
  end

  // Stage 2 register: final difference and flags, held stable while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_r  <= 1'b0;
      s2_diff_r   <= '0;
      s2_borrow_r <= 1'b0;
      s2_ovf_r    <= 1'b0;
      s2_zero_r   <= 1'b0;
    end else if (adv2_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_diff_r   <= res_s;
        s2_borrow_r <= borrow_s;
        s2_ovf_r    <= ovf_s;
        s2_zero_r   <= zero_s;
      end
    end
  end

  assign out_valid  = s2_valid_r;
  assign out_diff   = s2_diff_r;
  assign out_borrow = s2_borrow_r;
  assign out_ovf    = s2_ovf_r;
  assign out_zero   = s2_zero_r;

endmodule

// File: tb/tb_pipe_cla_subtractor.sv
// Self-checking bench for pipe_cla_subtractor (WIDTH=32).
// An arithmetic model scoreboards every accepted operation.
// Directed vectors carry hand-computed literal results.
module tb_pipe_cla_subtractor;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_diff;
  logic         out_borrow;
  logic         out_ovf;
  logic         out_zero;

  always #5 clk = ~clk;

  pipe_cla_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_diff(out_diff), .out_borrow(out_borrow), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         b;
    logic         o;
    logic         z;
  } res_t;

  int   tests = 0;
  int   fails = 0;
  res_t q[$];
  int   n_acc = 0;
  int   n_out = 0;
  res_t held;
  bit   held_v = 1'b0;

  // Model of the subtraction result from plain arithmetic
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    res_t r;
    logic [W:0] ext;
    logic signed [W:0] sd;
    ext = {1'b0, a} - {1'b0, b};
    r.d = ext[W-1:0];
    r.b = (a < b);
    sd  = $signed({a[W-1], a}) - $signed({b[W-1], b});
    r.o = sd[W] ^ sd[W-1];
`ifdef SUB_SAT_EN
    if (r.b) r.d = '0;
`endif
    r.z = (r.d == '0);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Scoreboard and stall-stability monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v)
        check("hold_stable", {out_valid, out_diff, out_borrow, out_ovf, out_zero}, {1'b1, held});
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          check("mon_result", {out_diff, out_borrow, out_ovf, out_zero}, q[0]);
          if (out_ready) begin
            void'(q.pop_front());
            n_out++;
          end
        end
        held_v = !out_ready;
        held   = {out_diff, out_borrow, out_ovf, out_zero};
      end else begin
        held_v = 1'b0;
      end
      if (in_valid && in_ready) begin
        q.push_back(model(in_a, in_b));
        n_acc++;
      end
    end
  end

  task automatic check_idle_zero(input string tag);
    check({tag, "_out_valid"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    check({tag, "_outputs"}, {out_diff, out_borrow, out_ovf, out_zero}, '0);
  endtask

  // One operation into an idle pipeline; checks the latency and the literal result
  task automatic send_check(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] ed, input logic eb, input logic eo, input logic ez);
    res_t exp;
    int   n;
    exp = {ed, eb, eo, ez};
    check("model_pin", model(a, b), exp);
    @(posedge clk); #1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    @(negedge clk);
    check("dir_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 8) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    check("dir_latency", n, 2);
    check("dir_result", {out_diff, out_borrow, out_ovf, out_zero}, exp);
  endtask

  task automatic drain();
    int c;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    c = 0;
    while (q.size() != 0 && c < 50) begin
      @(negedge clk);
      c++;
    end
    @(negedge clk);
    check("drain_empty", q.size(), 0);
  endtask

  // Offer ops[k] each cycle for ncyc cycles with out_ready held as given
  logic [W-1:0] sa [3];
  logic [W-1:0] sb [3];

  task automatic offer(input int ncyc, input logic ordy, inout int k);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      out_ready = ordy;
      in_valid  = (k < 3);
      in_a      = sa[k % 3];
      in_b      = sb[k % 3];
      @(negedge clk);
      if (in_valid && in_ready) k++;
    end
  endtask

  initial begin
    int  k;
    int  cyc;
    bit  hold;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");

    // Directed vectors
    send_check(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
`ifdef SUB_SAT_EN
    send_check(32'h0000_0000, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    send_check(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 1'b1);
`else
    send_check(32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    send_check(32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0);
`endif
    send_check(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
    send_check(32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1'b1);
    send_check(32'h0001_0000, 32'h0000_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1'b0);

    // Random stream with random back-pressure; inputs held until accepted
    k = 0; cyc = 0; hold = 1'b0;
    while (k < 1000 && cyc < 20000) begin
      @(posedge clk); #1;
      cyc++;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!hold) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = pick();
        in_b     = pick();
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        k++;
        hold = 1'b0;
      end else begin
        hold = in_valid;
      end
    end
    check("stream_count", k, 1000);
    drain();

    // Stall: three ops offered while the consumer is blocked
    sa[0] = 32'h0000_0010; sb[0] = 32'h0000_0001;
    sa[1] = 32'h0000_0000; sb[1] = 32'h0000_0002;
    sa[2] = 32'h1234_5678; sb[2] = 32'h1234_5678;
    k = 0;
    offer(5, 1'b0, k);
    check("stall_accepted", k, 2);
    check("stall_in_ready", in_ready, 1'b0);
    offer(4, 1'b1, k);
    check("stall_all_accepted", k, 3);
    drain();
    check("no_loss_dup", n_out, n_acc);

    // Reset with both stages full
    k = 0;
    offer(3, 1'b0, k);
    check("rst_prefill", k, 2);
    @(posedge clk); #1;
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("mid_reset");
    send_check(32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
